// File: rtl/mcu_subsys_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between two valid/ready masters.
// Optional grant watchdog enabled by defining MCU_SRAM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mcu_subsys_sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_mem_valid,
  output logic        m0_mem_ready,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  output logic        m1_mem_ready,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic [31:0] m1_mem_rdata,
  output logic        sram_mem_valid,
  input  logic        sram_mem_ready,
  output logic [31:0] sram_mem_addr,
  output logic [31:0] sram_mem_wdata,
  output logic [3:0]  sram_mem_wstrb,
  input  logic [31:0] sram_mem_rdata,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   gnt_valid;
  logic   to_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    gnt_valid = 1'b0;
    if (state_q == GNT0) gnt_valid = m0_mem_valid;
    if (state_q == GNT1) gnt_valid = m1_mem_valid;
  end

`ifdef MCU_SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!sram_mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th stalled grant cycle; a late ready wins.
  assign to_hit = gnt_valid && !sram_mem_ready &&
                  (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    sram_mem_valid = 1'b0;
    sram_mem_addr  = '0;
    sram_mem_wdata = '0;
    sram_mem_wstrb = '0;
    m0_mem_ready   = 1'b0;
    m0_mem_rdata   = '0;
    m1_mem_ready   = 1'b0;
    m1_mem_rdata   = '0;
    arb_timeout    = to_hit;
    unique case (state_q)
      IDLE: begin
        if (m0_mem_valid && (!m1_mem_valid || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_mem_valid) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        sram_mem_valid = m0_mem_valid & ~to_hit;
        sram_mem_addr  = m0_mem_addr;
        sram_mem_wdata = m0_mem_wdata;
        sram_mem_wstrb = m0_mem_wstrb;
        m0_mem_ready   = m0_mem_valid &
                         (sram_mem_ready | to_hit);
        m0_mem_rdata   = to_hit ? TIMEOUT_RDATA
                                : sram_mem_rdata;
        if (!m0_mem_valid || sram_mem_ready || to_hit) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        sram_mem_valid = m1_mem_valid & ~to_hit;
        sram_mem_addr  = m1_mem_addr;
        sram_mem_wdata = m1_mem_wdata;
        sram_mem_wstrb = m1_mem_wstrb;
        m1_mem_ready   = m1_mem_valid &
                         (sram_mem_ready | to_hit);
        m1_mem_rdata   = to_hit ? TIMEOUT_RDATA
                                : sram_mem_rdata;
        if (!m1_mem_valid || sram_mem_ready || to_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_q resets to m1 so that m0 wins the first tie.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mcu_subsys_sram_arbiter.sv
// Scoreboard bench for mcu_subsys_sram_arbiter: directed cases plus
// randomized two-master traffic against a behavioural SRAM model.
`timescale 1ns/1ps
module tb_mcu_subsys_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid [2];
  logic        m_ready [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_rdata [2];
  logic        sram_valid, sram_ready;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_wstrb;
  logic        arb_to;

  always #5 clk = ~clk;

  mcu_subsys_sram_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .sys_clk        (clk),
    .rst_n          (rst_n),
    .m0_mem_valid   (m_valid[0]),
    .m0_mem_ready   (m_ready[0]),
    .m0_mem_addr    (m_addr[0]),
    .m0_mem_wdata   (m_wdata[0]),
    .m0_mem_wstrb   (m_wstrb[0]),
    .m0_mem_rdata   (m_rdata[0]),
    .m1_mem_valid   (m_valid[1]),
    .m1_mem_ready   (m_ready[1]),
    .m1_mem_addr    (m_addr[1]),
    .m1_mem_wdata   (m_wdata[1]),
    .m1_mem_wstrb   (m_wstrb[1]),
    .m1_mem_rdata   (m_rdata[1]),
    .sram_mem_valid (sram_valid),
    .sram_mem_ready (sram_ready),
    .sram_mem_addr  (sram_addr),
    .sram_mem_wdata (sram_wdata),
    .sram_mem_wstrb (sram_wstrb),
    .sram_mem_rdata (sram_rdata),
    .arb_timeout    (arb_to)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t expq [2][$];
  int   order_q[$];
  int   time_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   sb_en = 0;
  bit   sram_auto = 0;
  bit   lat_rand = 0;
  int   lat_fix = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ready pops the owning master's queue.
  always @(negedge clk) begin : mon
    txn_t e;
    if (sb_en) begin
      if (m_ready[0] && m_ready[1])
        chk("both_ready", 32'(m_ready[0] & m_ready[1]), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (m_ready[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("m%0d_unexpected_ready", i),
                32'(m_ready[i]), 32'd0);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("m%0d_sram_addr", i), sram_addr, e.addr);
            chk($sformatf("m%0d_sram_wdata", i), sram_wdata, e.wdata);
            chk($sformatf("m%0d_sram_wstrb", i),
                32'(sram_wstrb), 32'(e.wstrb));
            chk($sformatf("m%0d_sram_valid", i), 32'(sram_valid), 32'd1);
            if (e.wstrb == 4'h0)
              chk($sformatf("m%0d_rdata", i), m_rdata[i],
                  mem_word(e.addr));
            chk($sformatf("m%0d_other_rdata", i), m_rdata[1-i], 32'd0);
            order_q.push_back(i);
            time_q.push_back(cyc);
          end
        end
      end
    end
  end

  // SRAM model: ready after a chosen number of stall cycles.
  initial begin : sram_model
    int cnt;
    bit busy;
    cnt = 0;
    busy = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sram_auto) begin
        if (sram_ready) begin
          sram_ready = 1'b0;
          busy = 0;
        end else if (sram_valid) begin
          if (!busy) begin
            busy = 1;
            cnt = lat_rand ? int'($urandom_range(3, 0)) : lat_fix;
          end
          if (cnt == 0) begin
            sram_ready = 1'b1;
            sram_rdata = mem_word(sram_addr);
          end else begin
            cnt--;
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic drive(input int id, input int n, input int maxgap);
    txn_t t;
    int   budget;
    bit   got;
    for (int k = 0; k < n; k++) begin
      t.addr  = $urandom & 32'hFFFF_FFFC;
      t.wdata = $urandom;
      t.wstrb = ($urandom_range(1, 0) == 0) ? 4'h0
                : 4'($urandom_range(15, 1));
      m_addr[id]  = t.addr;
      m_wdata[id] = t.wdata;
      m_wstrb[id] = t.wstrb;
      m_valid[id] = 1'b1;
      expq[id].push_back(t);
      got = 0;
      budget = 0;
      while (!got && budget < 200) begin
        @(negedge clk);
        if (m_ready[id]) got = 1;
        budget++;
      end
      chk($sformatf("m%0d_served_in_budget", id), 32'(got), 32'd1);
      if (!got) begin
        m_valid[id] = 1'b0;
        return;
      end
      step;
      m_valid[id] = 1'b0;
      if (maxgap > 0)
        repeat ($urandom_range(maxgap, 0)) step;
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_sram_valid"}, 32'(sram_valid), 32'd0);
    chk({nm, "_m0_ready"}, 32'(m_ready[0]), 32'd0);
    chk({nm, "_m1_ready"}, 32'(m_ready[1]), 32'd0);
    chk({nm, "_arb_timeout"}, 32'(arb_to), 32'd0);
    chk({nm, "_sram_addr"}, sram_addr, 32'd0);
    chk({nm, "_m0_rdata"}, m_rdata[0], 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_wstrb[i] = '0;
    end
    sram_ready = 1'b0;
    sram_rdata = '0;
    rst_n = 1'b0;
    repeat (3) step;
    check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    step;

    // Single m0 read, SRAM ready on the third grant cycle.
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h4000_0010;
    m_wstrb[0] = 4'h0;
    @(negedge clk);
    chk("t1_idle_valid", 32'(sram_valid), 32'd0);
    step;
    @(negedge clk);
    chk("t1_grant_valid", 32'(sram_valid), 32'd1);
    chk("t1_grant_addr", sram_addr, 32'h4000_0010);
    step;
    @(negedge clk);
    chk("t1_wait_ready", 32'(m_ready[0]), 32'd0);
    step;
    sram_ready = 1'b1;
    sram_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_m0_ready", 32'(m_ready[0]), 32'd1);
    chk("t1_m0_rdata", m_rdata[0], 32'h1234_5678);
    chk("t1_m1_ready", 32'(m_ready[1]), 32'd0);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b0;

    // m1 write arrives while m0 owns the port.
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h4000_0200;
    m_wdata[0] = 32'h1111_2222;
    m_wstrb[0] = 4'b1100;
    step;
    m_valid[1] = 1'b1;
    m_addr[1]  = 32'h4000_0100;
    m_wdata[1] = 32'hCAFE_F00D;
    m_wstrb[1] = 4'b0011;
    @(negedge clk);
    chk("t3_m0_addr", sram_addr, 32'h4000_0200);
    chk("t3_m0_wdata", sram_wdata, 32'h1111_2222);
    chk("t3_m0_wstrb", 32'(sram_wstrb), 32'(4'b1100));
    step;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t3_m0_ready", 32'(m_ready[0]), 32'd1);
    chk("t3_m1_wait", 32'(m_ready[1]), 32'd0);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_idle_gap", 32'(sram_valid), 32'd0);
    step;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t3_m1_addr", sram_addr, 32'h4000_0100);
    chk("t3_m1_wdata", sram_wdata, 32'hCAFE_F00D);
    chk("t3_m1_wstrb", 32'(sram_wstrb), 32'(4'b0011));
    chk("t3_m1_ready", 32'(m_ready[1]), 32'd1);
    chk("t3_m0_noready", 32'(m_ready[0]), 32'd0);
    step;
    sram_ready = 1'b0;
    m_valid[1] = 1'b0;

    // m0 abandons its request before the SRAM answers.
    m_valid[0] = 1'b1;
    m_wstrb[0] = 4'h0;
    step;
    @(negedge clk);
    chk("t4_granted", 32'(sram_valid), 32'd1);
    step;
    m_valid[0] = 1'b0;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t4_drop_valid", 32'(sram_valid), 32'd0);
    chk("t4_drop_noready", 32'(m_ready[0]), 32'd0);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_back_idle", 32'(sram_valid), 32'd0);
    step;
    @(negedge clk);
    chk("t4_regrant", 32'(sram_valid), 32'd1);
    step;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t4_done", 32'(m_ready[0]), 32'd1);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b0;

    // Reset during an m0 grant with m1 pending.
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h4000_0300;
    step;
    m_valid[1] = 1'b1;
    m_addr[1]  = 32'h4000_0400;
    m_wstrb[1] = 4'h0;
    sram_ready = 1'b1;
    sram_rdata = 32'h0BAD_F00D;
    #1;
    chk("t5_pre_ready", 32'(m_ready[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    sram_ready = 1'b0;
    step;
    @(negedge clk) rst_n = 1'b1;
    step;
    @(negedge clk);
    chk("t5_first_tie_addr", sram_addr, 32'h4000_0300);
    chk("t5_first_tie_valid", 32'(sram_valid), 32'd1);
    step;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t5_m0_ready", 32'(m_ready[0]), 32'd1);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b0;
    step;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("t5_m1_ready", 32'(m_ready[1]), 32'd1);
    step;
    sram_ready = 1'b0;
    m_valid[1] = 1'b0;

    // Continuous contention from reset: strict alternation.
    rst_n = 1'b0;
    step;
    @(negedge clk) rst_n = 1'b1;
    step;
    order_q.delete();
    time_q.delete();
    sb_en = 1;
    sram_auto = 1;
    lat_rand = 0;
    lat_fix = 1;
    fork
      drive(0, 4, 0);
      drive(1, 4, 0);
    join
    chk("t2_count", 32'(order_q.size()), 32'd8);
    for (int i = 0; i < order_q.size(); i++)
      chk($sformatf("t2_order%0d", i), 32'(order_q[i]), 32'(i % 2));
    for (int i = 1; i < time_q.size(); i++)
      chk($sformatf("t2_spacing%0d", i),
          32'(time_q[i] - time_q[i-1]), 32'(lat_fix + 2));

    // Randomized traffic with random SRAM latency.
    lat_rand = 1;
    fork
      drive(0, 40, 3);
      drive(1, 40, 3);
    join
    repeat (3) step;
    chk("rand_q0_empty", 32'(expq[0].size()), 32'd0);
    chk("rand_q1_empty", 32'(expq[1].size()), 32'd0);
    sb_en = 0;
    sram_auto = 0;
    step;
    sram_ready = 1'b0;

    // SRAM never answers.
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h4000_0500;
    m_wstrb[0] = 4'h0;
`ifdef MCU_SRAM_ARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      step;
      @(negedge clk);
      if (i < 8) begin
        chk($sformatf("to_wait%0d", i), 32'(m_ready[0] | arb_to), 32'd0);
      end else begin
        chk("to_ready", 32'(m_ready[0]), 32'd1);
        chk("to_rdata", m_rdata[0], 32'hDEAD_BEEF);
        chk("to_pulse", 32'(arb_to), 32'd1);
        chk("to_sram_valid", 32'(sram_valid), 32'd0);
      end
    end
    step;
    m_valid[0] = 1'b0;
    @(negedge clk);
    chk("to_pulse_end", 32'(arb_to), 32'd0);
`else
    bad = 0;
    repeat (1000) begin
      step;
      @(negedge clk);
      if (m_ready[0] || arb_to) bad++;
    end
    chk("noto_no_ready", 32'(bad), 32'd0);
    chk("noto_still_granted", 32'(sram_valid), 32'd1);
    sram_ready = 1'b1;
    sram_rdata = 32'h7777_0000;
    #1;
    chk("noto_late_ready", 32'(m_ready[0]), 32'd1);
    chk("noto_late_rdata", m_rdata[0], 32'h7777_0000);
    step;
    sram_ready = 1'b0;
    m_valid[0] = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
